// File: rtl/iq_pkg.sv
// Shared types and helpers for the parametrised integer issue queue.
package iq_pkg;

    localparam int unsigned IQ_DEPTH  = 4;
    localparam int unsigned IQ_DATA_W = 32;
    localparam int unsigned IQ_TAG_W  = 5;
    localparam int unsigned IQ_OPC_W  = 4;
    localparam int unsigned IQ_SHF_W  = 5;

    // One queue entry's payload at the default field widths.
    typedef struct packed {
        logic [IQ_OPC_W-1:0]  opcode;
        logic [IQ_SHF_W-1:0]  shfamt;
        logic [IQ_TAG_W-1:0]  rd_tag;
        logic [IQ_TAG_W-1:0]  rs_tag;
        logic [IQ_TAG_W-1:0]  rt_tag;
        logic [IQ_DATA_W-1:0] rs_data;
        logic [IQ_DATA_W-1:0] rt_data;
        logic                 rs_val;
        logic                 rt_val;
    } iq_entry_t;

    // Ceiling log2; returns 0 for an argument of 0 or 1.
    function automatic int unsigned iq_clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_entry.sv
// Single issue-queue slot: holds, shifts in from the younger neighbour, or
// loads a dispatched entry, and snoops the CDB for operand wakeup.
module iq_entry
    import iq_pkg::*;
#(
    parameter int unsigned DATA_W = IQ_DATA_W,
    parameter int unsigned TAG_W  = IQ_TAG_W,
    parameter int unsigned OPC_W  = IQ_OPC_W,
    parameter int unsigned SHF_W  = IQ_SHF_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_flush,
    input  logic              i_shift,
    input  logic              i_load,
    input  logic              i_up_valid,
    input  logic [OPC_W-1:0]  i_up_opcode,
    input  logic [SHF_W-1:0]  i_up_shfamt,
    input  logic [TAG_W-1:0]  i_up_rd_tag,
    input  logic [TAG_W-1:0]  i_up_rs_tag,
    input  logic [TAG_W-1:0]  i_up_rt_tag,
    input  logic [DATA_W-1:0] i_up_rs_data,
    input  logic [DATA_W-1:0] i_up_rt_data,
    input  logic              i_up_rs_val,
    input  logic              i_up_rt_val,
    input  logic [OPC_W-1:0]  i_dsp_opcode,
    input  logic [SHF_W-1:0]  i_dsp_shfamt,
    input  logic [TAG_W-1:0]  i_dsp_rd_tag,
    input  logic [TAG_W-1:0]  i_dsp_rs_tag,
    input  logic [TAG_W-1:0]  i_dsp_rt_tag,
    input  logic [DATA_W-1:0] i_dsp_rs_data,
    input  logic [DATA_W-1:0] i_dsp_rt_data,
    input  logic              i_dsp_rs_val,
    input  logic              i_dsp_rt_val,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    output logic              o_valid,
    output logic [OPC_W-1:0]  o_opcode,
    output logic [SHF_W-1:0]  o_shfamt,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [TAG_W-1:0]  o_rs_tag,
    output logic [TAG_W-1:0]  o_rt_tag,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic              o_rs_val,
    output logic              o_rt_val
);

    logic              r_valid;
    logic [OPC_W-1:0]  r_opcode;
    logic [SHF_W-1:0]  r_shfamt;
    logic [TAG_W-1:0]  r_rd_tag;
    logic [TAG_W-1:0]  r_rs_tag;
    logic [TAG_W-1:0]  r_rt_tag;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic              r_rs_val;
    logic              r_rt_val;

    logic              w_nx_valid;
    logic [OPC_W-1:0]  w_nx_opcode;
    logic [SHF_W-1:0]  w_nx_shfamt;
    logic [TAG_W-1:0]  w_nx_rd_tag;
    logic [TAG_W-1:0]  w_nx_rs_tag;
    logic [TAG_W-1:0]  w_nx_rt_tag;
    logic [DATA_W-1:0] w_nx_rs_data;
    logic [DATA_W-1:0] w_nx_rt_data;
    logic              w_nx_rs_val;
    logic              w_nx_rt_val;

    // Pick hold/shift source, apply CDB wakeup to it, then let a dispatch load override.
    always_comb begin
        w_nx_valid   = i_shift ? i_up_valid   : r_valid;
        w_nx_opcode  = i_shift ? i_up_opcode  : r_opcode;
        w_nx_shfamt  = i_shift ? i_up_shfamt  : r_shfamt;
        w_nx_rd_tag  = i_shift ? i_up_rd_tag  : r_rd_tag;
        w_nx_rs_tag  = i_shift ? i_up_rs_tag  : r_rs_tag;
        w_nx_rt_tag  = i_shift ? i_up_rt_tag  : r_rt_tag;
        w_nx_rs_data = i_shift ? i_up_rs_data : r_rs_data;
        w_nx_rt_data = i_shift ? i_up_rt_data : r_rt_data;
        w_nx_rs_val  = i_shift ? i_up_rs_val  : r_rs_val;
        w_nx_rt_val  = i_shift ? i_up_rt_val  : r_rt_val;

        if (i_cdb_valid && !w_nx_rs_val && (w_nx_rs_tag == i_cdb_tag)) begin
            w_nx_rs_data = i_cdb_data;
            w_nx_rs_val  = 1'b1;
        end
        if (i_cdb_valid && !w_nx_rt_val && (w_nx_rt_tag == i_cdb_tag)) begin
            w_nx_rt_data = i_cdb_data;
            w_nx_rt_val  = 1'b1;
        end

        if (i_load) begin
            w_nx_valid   = 1'b1;
            w_nx_opcode  = i_dsp_opcode;
            w_nx_shfamt  = i_dsp_shfamt;
            w_nx_rd_tag  = i_dsp_rd_tag;
            w_nx_rs_tag  = i_dsp_rs_tag;
            w_nx_rt_tag  = i_dsp_rt_tag;
            w_nx_rs_data = i_dsp_rs_data;
            w_nx_rt_data = i_dsp_rt_data;
            w_nx_rs_val  = i_dsp_rs_val;
            w_nx_rt_val  = i_dsp_rt_val;
        end

        if (i_flush) begin
            w_nx_valid = 1'b0;
        end
    end

    // Slot state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_valid   <= 1'b0;
            r_opcode  <= '0;
            r_shfamt  <= '0;
            r_rd_tag  <= '0;
            r_rs_tag  <= '0;
            r_rt_tag  <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_rs_val  <= 1'b0;
            r_rt_val  <= 1'b0;
        end else begin
            r_valid   <= w_nx_valid;
            r_opcode  <= w_nx_opcode;
            r_shfamt  <= w_nx_shfamt;
            r_rd_tag  <= w_nx_rd_tag;
            r_rs_tag  <= w_nx_rs_tag;
            r_rt_tag  <= w_nx_rt_tag;
            r_rs_data <= w_nx_rs_data;
            r_rt_data <= w_nx_rt_data;
            r_rs_val  <= w_nx_rs_val;
            r_rt_val  <= w_nx_rt_val;
        end
    end

    assign o_valid   = r_valid;
    assign o_opcode  = r_opcode;
    assign o_shfamt  = r_shfamt;
    assign o_rd_tag  = r_rd_tag;
    assign o_rs_tag  = r_rs_tag;
    assign o_rt_tag  = r_rt_tag;
    assign o_rs_data = r_rs_data;
    assign o_rt_data = r_rt_data;
    assign o_rs_val  = r_rs_val;
    assign o_rt_val  = r_rt_val;

endmodule

// File: rtl/issue_queue_param.sv
// Collapsing, age-ordered integer issue queue with CDB wakeup, dispatch
// bypass, occupancy count and almost-full flag. Slot 0 is the oldest.
module issue_queue_param
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH    = IQ_DEPTH,
    parameter int unsigned DATA_W   = IQ_DATA_W,
    parameter int unsigned TAG_W    = IQ_TAG_W,
    parameter int unsigned OPC_W    = IQ_OPC_W,
    parameter int unsigned SHF_W    = IQ_SHF_W,
    parameter int unsigned AFULL_TH = DEPTH - 1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Dispatch_Enable,
    input  logic [OPC_W-1:0]               Dispatch_Opcode,
    input  logic [SHF_W-1:0]               Dispatch_Shfamt,
    input  logic [TAG_W-1:0]               Dispatch_Rd_Tag,
    input  logic [DATA_W-1:0]              Dispatch_Rs_Data,
    input  logic [DATA_W-1:0]              Dispatch_Rt_Data,
    input  logic [TAG_W-1:0]               Dispatch_Rs_Tag,
    input  logic [TAG_W-1:0]               Dispatch_Rt_Tag,
    input  logic                           Dispatch_Rs_Data_Val,
    input  logic                           Dispatch_Rt_Data_Val,
    output logic                           IssueQue_Full,
    output logic                           IssueQue_AlmostFull,
    output logic [iq_clog2(DEPTH+1)-1:0]   IssueQue_Count,
    input  logic                           CDB_Valid,
    input  logic [TAG_W-1:0]               CDB_Tag,
    input  logic [DATA_W-1:0]              CDB_Data,
    output logic                           IssueQue_Ready,
    output logic [OPC_W-1:0]               IssueQue_Opcode,
    output logic [SHF_W-1:0]               IssueQue_Shfamt,
    output logic [TAG_W-1:0]               IssueQue_Rd_Tag,
    output logic [DATA_W-1:0]              IssueQue_Rs_Data,
    output logic [DATA_W-1:0]              IssueQue_Rt_Data,
    input  logic                           Issueblk_Issue,
    input  logic                           RB_Flush_Valid
);

    localparam int unsigned IDX_W = iq_clog2(DEPTH);
    localparam int unsigned CNT_W = iq_clog2(DEPTH + 1);

    logic [CNT_W-1:0]  r_count;

    logic              w_e_valid   [DEPTH];
    logic [OPC_W-1:0]  w_e_opcode  [DEPTH];
    logic [SHF_W-1:0]  w_e_shfamt  [DEPTH];
    logic [TAG_W-1:0]  w_e_rd_tag  [DEPTH];
    logic [TAG_W-1:0]  w_e_rs_tag  [DEPTH];
    logic [TAG_W-1:0]  w_e_rt_tag  [DEPTH];
    logic [DATA_W-1:0] w_e_rs_data [DEPTH];
    logic [DATA_W-1:0] w_e_rt_data [DEPTH];
    logic              w_e_rs_val  [DEPTH];
    logic              w_e_rt_val  [DEPTH];

    logic              w_up_valid   [DEPTH];
    logic [OPC_W-1:0]  w_up_opcode  [DEPTH];
    logic [SHF_W-1:0]  w_up_shfamt  [DEPTH];
    logic [TAG_W-1:0]  w_up_rd_tag  [DEPTH];
    logic [TAG_W-1:0]  w_up_rs_tag  [DEPTH];
    logic [TAG_W-1:0]  w_up_rt_tag  [DEPTH];
    logic [DATA_W-1:0] w_up_rs_data [DEPTH];
    logic [DATA_W-1:0] w_up_rt_data [DEPTH];
    logic              w_up_rs_val  [DEPTH];
    logic              w_up_rt_val  [DEPTH];

    logic [DEPTH-1:0]  w_rdy;
    logic [DEPTH-1:0]  w_shift;
    logic [DEPTH-1:0]  w_load;
    logic [IDX_W-1:0]  w_sel;
    logic              w_ready;
    logic              w_fire;
    logic              w_full;
    logic              w_accept;
    logic [CNT_W-1:0]  w_wr_idx;

    logic              w_dsp_rs_hit;
    logic              w_dsp_rt_hit;
    logic              w_dsp_rs_val;
    logic              w_dsp_rt_val;
    logic [DATA_W-1:0] w_dsp_rs_data;
    logic [DATA_W-1:0] w_dsp_rt_data;

    // Dispatch bypass: a waiting operand whose tag is on the CDB this cycle is captured directly.
    assign w_dsp_rs_hit  = CDB_Valid & ~Dispatch_Rs_Data_Val & (Dispatch_Rs_Tag == CDB_Tag);
    assign w_dsp_rt_hit  = CDB_Valid & ~Dispatch_Rt_Data_Val & (Dispatch_Rt_Tag == CDB_Tag);
    assign w_dsp_rs_val  = Dispatch_Rs_Data_Val | w_dsp_rs_hit;
    assign w_dsp_rt_val  = Dispatch_Rt_Data_Val | w_dsp_rt_hit;
    assign w_dsp_rs_data = w_dsp_rs_hit ? CDB_Data : Dispatch_Rs_Data;
    assign w_dsp_rt_data = w_dsp_rt_hit ? CDB_Data : Dispatch_Rt_Data;

    // Slot array; each slot shifts in from its younger neighbour, the top slot from an empty entry.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == DEPTH - 1) begin : g_last
            assign w_up_valid[g]   = 1'b0;
            assign w_up_opcode[g]  = '0;
            assign w_up_shfamt[g]  = '0;
            assign w_up_rd_tag[g]  = '0;
            assign w_up_rs_tag[g]  = '0;
            assign w_up_rt_tag[g]  = '0;
            assign w_up_rs_data[g] = '0;
            assign w_up_rt_data[g] = '0;
            assign w_up_rs_val[g]  = 1'b0;
            assign w_up_rt_val[g]  = 1'b0;
        end else begin : g_mid
            assign w_up_valid[g]   = w_e_valid[g+1];
            assign w_up_opcode[g]  = w_e_opcode[g+1];
            assign w_up_shfamt[g]  = w_e_shfamt[g+1];
            assign w_up_rd_tag[g]  = w_e_rd_tag[g+1];
            assign w_up_rs_tag[g]  = w_e_rs_tag[g+1];
            assign w_up_rt_tag[g]  = w_e_rt_tag[g+1];
            assign w_up_rs_data[g] = w_e_rs_data[g+1];
            assign w_up_rt_data[g] = w_e_rt_data[g+1];
            assign w_up_rs_val[g]  = w_e_rs_val[g+1];
            assign w_up_rt_val[g]  = w_e_rt_val[g+1];
        end

        assign w_rdy[g] = w_e_valid[g] & w_e_rs_val[g] & w_e_rt_val[g];

        iq_entry #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .OPC_W  (OPC_W),
            .SHF_W  (SHF_W)
        ) u_entry (
            .Clk           (Clk),
            .Rst           (Rst),
            .i_flush       (RB_Flush_Valid),
            .i_shift       (w_shift[g]),
            .i_load        (w_load[g]),
            .i_up_valid    (w_up_valid[g]),
            .i_up_opcode   (w_up_opcode[g]),
            .i_up_shfamt   (w_up_shfamt[g]),
            .i_up_rd_tag   (w_up_rd_tag[g]),
            .i_up_rs_tag   (w_up_rs_tag[g]),
            .i_up_rt_tag   (w_up_rt_tag[g]),
            .i_up_rs_data  (w_up_rs_data[g]),
            .i_up_rt_data  (w_up_rt_data[g]),
            .i_up_rs_val   (w_up_rs_val[g]),
            .i_up_rt_val   (w_up_rt_val[g]),
            .i_dsp_opcode  (Dispatch_Opcode),
            .i_dsp_shfamt  (Dispatch_Shfamt),
            .i_dsp_rd_tag  (Dispatch_Rd_Tag),
            .i_dsp_rs_tag  (Dispatch_Rs_Tag),
            .i_dsp_rt_tag  (Dispatch_Rt_Tag),
            .i_dsp_rs_data (w_dsp_rs_data),
            .i_dsp_rt_data (w_dsp_rt_data),
            .i_dsp_rs_val  (w_dsp_rs_val),
            .i_dsp_rt_val  (w_dsp_rt_val),
            .i_cdb_valid   (CDB_Valid),
            .i_cdb_tag     (CDB_Tag),
            .i_cdb_data    (CDB_Data),
            .o_valid       (w_e_valid[g]),
            .o_opcode      (w_e_opcode[g]),
            .o_shfamt      (w_e_shfamt[g]),
            .o_rd_tag      (w_e_rd_tag[g]),
            .o_rs_tag      (w_e_rs_tag[g]),
            .o_rt_tag      (w_e_rt_tag[g]),
            .o_rs_data     (w_e_rs_data[g]),
            .o_rt_data     (w_e_rt_data[g]),
            .o_rs_val      (w_e_rs_val[g]),
            .o_rt_val      (w_e_rt_val[g])
        );
    end

    // Oldest-first select: lowest ready index wins, slot 0 when nothing is ready.
    always_comb begin
        w_sel   = '0;
        w_ready = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_sel   = IDX_W'(i);
                w_ready = 1'b1;
            end
        end
    end

    assign w_fire   = Issueblk_Issue & w_ready;
    assign w_full   = (r_count == CNT_W'(DEPTH)) & ~w_fire;
    assign w_accept = Dispatch_Enable & ~w_full & ~RB_Flush_Valid;
    assign w_wr_idx = r_count - CNT_W'(w_fire);

    // Collapse slots at and above the issued one; land a dispatch just past the surviving entries.
    always_comb begin
        w_shift = '0;
        w_load  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_shift[i] = w_fire & (IDX_W'(i) >= w_sel);
            w_load[i]  = w_accept & (CNT_W'(i) == w_wr_idx);
        end
    end

    // Occupancy counter; flush empties the queue.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
        end else if (RB_Flush_Valid) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_fire);
        end
    end

    assign IssueQue_Full       = w_full;
    assign IssueQue_AlmostFull = (r_count >= CNT_W'(AFULL_TH));
    assign IssueQue_Count      = r_count;
    assign IssueQue_Ready      = w_ready;
    assign IssueQue_Opcode     = w_e_opcode[w_sel];
    assign IssueQue_Shfamt     = w_e_shfamt[w_sel];
    assign IssueQue_Rd_Tag     = w_e_rd_tag[w_sel];
    assign IssueQue_Rs_Data    = w_e_rs_data[w_sel];
    assign IssueQue_Rt_Data    = w_e_rt_data[w_sel];

endmodule

// File: tb/tb_issue_queue_param.sv
// Randomized plus directed bench for issue_queue_param against a queue-based model.
module tb_issue_queue_param;
    import iq_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        Clk;
    logic        Rst;
    logic        Dispatch_Enable;
    logic [3:0]  Dispatch_Opcode;
    logic [4:0]  Dispatch_Shfamt;
    logic [4:0]  Dispatch_Rd_Tag;
    logic [31:0] Dispatch_Rs_Data;
    logic [31:0] Dispatch_Rt_Data;
    logic [4:0]  Dispatch_Rs_Tag;
    logic [4:0]  Dispatch_Rt_Tag;
    logic        Dispatch_Rs_Data_Val;
    logic        Dispatch_Rt_Data_Val;
    logic        IssueQue_Full;
    logic        IssueQue_AlmostFull;
    logic [2:0]  IssueQue_Count;
    logic        CDB_Valid;
    logic [4:0]  CDB_Tag;
    logic [31:0] CDB_Data;
    logic        IssueQue_Ready;
    logic [3:0]  IssueQue_Opcode;
    logic [4:0]  IssueQue_Shfamt;
    logic [4:0]  IssueQue_Rd_Tag;
    logic [31:0] IssueQue_Rs_Data;
    logic [31:0] IssueQue_Rt_Data;
    logic        Issueblk_Issue;
    logic        RB_Flush_Valid;

    int n_cmp = 0;
    int n_err = 0;

    iq_entry_t q[$];
    iq_entry_t q_nxt[$];

    issue_queue_param dut (
        .Clk                  (Clk),
        .Rst                  (Rst),
        .Dispatch_Enable      (Dispatch_Enable),
        .Dispatch_Opcode      (Dispatch_Opcode),
        .Dispatch_Shfamt      (Dispatch_Shfamt),
        .Dispatch_Rd_Tag      (Dispatch_Rd_Tag),
        .Dispatch_Rs_Data     (Dispatch_Rs_Data),
        .Dispatch_Rt_Data     (Dispatch_Rt_Data),
        .Dispatch_Rs_Tag      (Dispatch_Rs_Tag),
        .Dispatch_Rt_Tag      (Dispatch_Rt_Tag),
        .Dispatch_Rs_Data_Val (Dispatch_Rs_Data_Val),
        .Dispatch_Rt_Data_Val (Dispatch_Rt_Data_Val),
        .IssueQue_Full        (IssueQue_Full),
        .IssueQue_AlmostFull  (IssueQue_AlmostFull),
        .IssueQue_Count       (IssueQue_Count),
        .CDB_Valid            (CDB_Valid),
        .CDB_Tag              (CDB_Tag),
        .CDB_Data             (CDB_Data),
        .IssueQue_Ready       (IssueQue_Ready),
        .IssueQue_Opcode      (IssueQue_Opcode),
        .IssueQue_Shfamt      (IssueQue_Shfamt),
        .IssueQue_Rd_Tag      (IssueQue_Rd_Tag),
        .IssueQue_Rs_Data     (IssueQue_Rs_Data),
        .IssueQue_Rt_Data     (IssueQue_Rt_Data),
        .Issueblk_Issue       (Issueblk_Issue),
        .RB_Flush_Valid       (RB_Flush_Valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        Dispatch_Enable      = 1'b0;
        Dispatch_Opcode      = '0;
        Dispatch_Shfamt      = '0;
        Dispatch_Rd_Tag      = '0;
        Dispatch_Rs_Data     = '0;
        Dispatch_Rt_Data     = '0;
        Dispatch_Rs_Tag      = '0;
        Dispatch_Rt_Tag      = '0;
        Dispatch_Rs_Data_Val = 1'b0;
        Dispatch_Rt_Data_Val = 1'b0;
        CDB_Valid            = 1'b0;
        CDB_Tag              = '0;
        CDB_Data             = '0;
        Issueblk_Issue       = 1'b0;
        RB_Flush_Valid       = 1'b0;
    endtask

    task automatic set_disp(input int rd, input int rs_tag, input logic rs_val,
                            input int rt_tag, input logic rt_val);
        Dispatch_Enable      = 1'b1;
        Dispatch_Opcode      = 4'(rd);
        Dispatch_Shfamt      = 5'(rd + 3);
        Dispatch_Rd_Tag      = 5'(rd);
        Dispatch_Rs_Tag      = 5'(rs_tag);
        Dispatch_Rt_Tag      = 5'(rt_tag);
        Dispatch_Rs_Data     = 32'h1000 + 32'(rd);
        Dispatch_Rt_Data     = 32'h2000 + 32'(rd);
        Dispatch_Rs_Data_Val = rs_val;
        Dispatch_Rt_Data_Val = rt_val;
    endtask

    // Index of the oldest entry with both operands available, -1 if none.
    function automatic int oldest_ready();
        for (int k = 0; k < q.size(); k++)
            if (q[k].rs_val && q[k].rt_val) return k;
        return -1;
    endfunction

    task automatic check_outputs();
        int  s;
        logic rdy;
        s   = oldest_ready();
        rdy = (s >= 0);
        chk("count", 64'(IssueQue_Count), 64'(q.size()));
        chk("ready", 64'(IssueQue_Ready), 64'(rdy));
        chk("full", 64'(IssueQue_Full), 64'((q.size() == DEPTH) && !(Issueblk_Issue && rdy)));
        chk("afull", 64'(IssueQue_AlmostFull), 64'(q.size() >= DEPTH - 1));
        if (rdy) begin
            chk("opcode", 64'(IssueQue_Opcode), 64'(q[s].opcode));
            chk("shfamt", 64'(IssueQue_Shfamt), 64'(q[s].shfamt));
            chk("rd_tag", 64'(IssueQue_Rd_Tag), 64'(q[s].rd_tag));
            chk("rs_data", 64'(IssueQue_Rs_Data), 64'(q[s].rs_data));
            chk("rt_data", 64'(IssueQue_Rt_Data), 64'(q[s].rt_data));
        end else if (q.size() > 0) begin
            chk("head_opcode", 64'(IssueQue_Opcode), 64'(q[0].opcode));
            chk("head_rd_tag", 64'(IssueQue_Rd_Tag), 64'(q[0].rd_tag));
        end
    endtask

    // Next queue contents from the current inputs: wake, remove the issued one, append, flush.
    task automatic model_next();
        int        s;
        logic      fire;
        logic      full;
        logic      acc;
        iq_entry_t e;
        s    = oldest_ready();
        fire = Issueblk_Issue && (s >= 0);
        full = (q.size() == DEPTH) && !fire;
        acc  = Dispatch_Enable && !full && !RB_Flush_Valid;
        q_nxt = q;
        for (int k = 0; k < q_nxt.size(); k++) begin
            if (CDB_Valid && !q_nxt[k].rs_val && q_nxt[k].rs_tag == CDB_Tag) begin
                q_nxt[k].rs_val  = 1'b1;
                q_nxt[k].rs_data = CDB_Data;
            end
            if (CDB_Valid && !q_nxt[k].rt_val && q_nxt[k].rt_tag == CDB_Tag) begin
                q_nxt[k].rt_val  = 1'b1;
                q_nxt[k].rt_data = CDB_Data;
            end
        end
        if (fire) q_nxt.delete(s);
        if (acc) begin
            e.opcode  = Dispatch_Opcode;
            e.shfamt  = Dispatch_Shfamt;
            e.rd_tag  = Dispatch_Rd_Tag;
            e.rs_tag  = Dispatch_Rs_Tag;
            e.rt_tag  = Dispatch_Rt_Tag;
            e.rs_val  = Dispatch_Rs_Data_Val || (CDB_Valid && CDB_Tag == Dispatch_Rs_Tag);
            e.rt_val  = Dispatch_Rt_Data_Val || (CDB_Valid && CDB_Tag == Dispatch_Rt_Tag);
            e.rs_data = (!Dispatch_Rs_Data_Val && CDB_Valid && CDB_Tag == Dispatch_Rs_Tag)
                        ? CDB_Data : Dispatch_Rs_Data;
            e.rt_data = (!Dispatch_Rt_Data_Val && CDB_Valid && CDB_Tag == Dispatch_Rt_Tag)
                        ? CDB_Data : Dispatch_Rt_Data;
            q_nxt.push_back(e);
        end
        if (RB_Flush_Valid) q_nxt.delete();
    endtask

    // One cycle: check outputs against the model, clock, commit the model.
    task automatic step();
        #1;
        check_outputs();
        model_next();
        @(posedge Clk);
        q = q_nxt;
        @(negedge Clk);
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);

        chk("rst_count", 64'(IssueQue_Count), 64'd0);
        chk("rst_ready", 64'(IssueQue_Ready), 64'd0);
        chk("rst_full", 64'(IssueQue_Full), 64'd0);
        chk("rst_afull", 64'(IssueQue_AlmostFull), 64'd0);
        chk("rst_rd_tag", 64'(IssueQue_Rd_Tag), 64'd0);
        chk("rst_rs_data", 64'(IssueQue_Rs_Data), 64'd0);
        chk("rst_rt_data", 64'(IssueQue_Rt_Data), 64'd0);
        Rst = 1'b0;

        // Fill with four ready entries, then try a fifth.
        for (int r = 1; r <= 4; r++) begin
            set_disp(r, 0, 1'b1, 0, 1'b1);
            step();
            chk("fill_count", 64'(IssueQue_Count), 64'(r));
            if (r == 3) chk("afull_at3", 64'(IssueQue_AlmostFull), 64'd1);
        end
        idle();
        #1;
        chk("fill_full", 64'(IssueQue_Full), 64'd1);
        set_disp(5, 0, 1'b1, 0, 1'b1);
        step();
        chk("fifth_dropped", 64'(IssueQue_Count), 64'd4);
        idle();
        Issueblk_Issue = 1'b1;
        repeat (4) step();
        idle();

        // Head waits on tag 7; issue plus dispatch on a full queue.
        set_disp(1, 7, 1'b0, 0, 1'b1);
        step();
        for (int r = 2; r <= 4; r++) begin
            set_disp(r, 0, 1'b1, 0, 1'b1);
            step();
        end
        set_disp(9, 0, 1'b1, 0, 1'b1);
        Issueblk_Issue = 1'b1;
        #1;
        chk("issue_rd2", 64'(IssueQue_Rd_Tag), 64'd2);
        chk("not_full_on_issue", 64'(IssueQue_Full), 64'd0);
        step();
        idle();
        chk("count_held", 64'(IssueQue_Count), 64'd4);
        RB_Flush_Valid = 1'b1;
        step();
        idle();

        // Wakeup while the waiting entry shifts from slot 2 to slot 1.
        set_disp(5, 0, 1'b1, 0, 1'b1);
        step();
        set_disp(6, 0, 1'b1, 0, 1'b1);
        step();
        set_disp(7, 7, 1'b0, 0, 1'b1);
        step();
        idle();
        Issueblk_Issue = 1'b1;
        CDB_Valid      = 1'b1;
        CDB_Tag        = 5'd7;
        CDB_Data       = 32'hDEADBEEF;
        step();
        idle();
        Issueblk_Issue = 1'b1;
        step();
        idle();
        #1;
        chk("shift_wake_ready", 64'(IssueQue_Ready), 64'd1);
        chk("shift_wake_rd", 64'(IssueQue_Rd_Tag), 64'd7);
        chk("shift_wake_rs", 64'(IssueQue_Rs_Data), 64'hDEADBEEF);
        RB_Flush_Valid = 1'b1;
        step();
        idle();

        // Dispatch bypass from the CDB.
        set_disp(8, 0, 1'b1, 12, 1'b0);
        CDB_Valid = 1'b1;
        CDB_Tag   = 5'd12;
        CDB_Data  = 32'h55;
        step();
        idle();
        #1;
        chk("bypass_ready", 64'(IssueQue_Ready), 64'd1);
        chk("bypass_rt", 64'(IssueQue_Rt_Data), 64'h55);
        RB_Flush_Valid = 1'b1;
        step();
        idle();

        // Flush with three held entries and a concurrent dispatch.
        for (int r = 1; r <= 3; r++) begin
            set_disp(r + 10, 3, 1'b0, 0, 1'b1);
            step();
        end
        set_disp(20, 0, 1'b1, 0, 1'b1);
        RB_Flush_Valid = 1'b1;
        step();
        idle();
        #1;
        chk("flush_count", 64'(IssueQue_Count), 64'd0);
        chk("flush_ready", 64'(IssueQue_Ready), 64'd0);
        chk("flush_full", 64'(IssueQue_Full), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            Dispatch_Enable      = ($urandom_range(0, 2) != 0);
            Dispatch_Opcode      = 4'($urandom);
            Dispatch_Shfamt      = 5'($urandom);
            Dispatch_Rd_Tag      = 5'($urandom);
            Dispatch_Rs_Tag      = 5'($urandom_range(0, 7));
            Dispatch_Rt_Tag      = 5'($urandom_range(0, 7));
            Dispatch_Rs_Data     = $urandom;
            Dispatch_Rt_Data     = $urandom;
            Dispatch_Rs_Data_Val = 1'($urandom_range(0, 1));
            Dispatch_Rt_Data_Val = 1'($urandom_range(0, 1));
            CDB_Valid            = 1'($urandom_range(0, 1));
            CDB_Tag              = 5'($urandom_range(0, 7));
            CDB_Data             = $urandom;
            Issueblk_Issue       = ($urandom_range(0, 3) != 0);
            RB_Flush_Valid       = ($urandom_range(0, 49) == 0);
            step();
        end
        idle();

        // Asynchronous reset between edges with entries held.
        set_disp(30, 4, 1'b0, 0, 1'b1);
        step();
        set_disp(31, 4, 1'b0, 0, 1'b1);
        step();
        idle();
        #2;
        Rst = 1'b1;
        #1;
        chk("async_rst_ready", 64'(IssueQue_Ready), 64'd0);
        chk("async_rst_count", 64'(IssueQue_Count), 64'd0);
        chk("async_rst_rd", 64'(IssueQue_Rd_Tag), 64'd0);
        chk("async_rst_rs", 64'(IssueQue_Rs_Data), 64'd0);
        chk("async_rst_opc", 64'(IssueQue_Opcode), 64'd0);
        q.delete();
        @(negedge Clk);
        Rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
